// File: rtl/cam_lookup_insert_ctrl_pkg.sv
// Shared encodings for the CAM request controller: operation codes and FSM states.
package cam_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMPARE = 3'd1,
        S_EVAL    = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT    = 3'd4,
        S_RESP    = 3'd5
    } state_e;

endpackage

// File: rtl/cam_lookup_insert_ctrl_free_slot_finder.sv
// Combinational lowest-index clear-bit encoder over the occupancy bitmap.
module free_slot_finder #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [2**ADDR_WIDTH-1:0] bitmap,
    output logic                     found,
    output logic [ADDR_WIDTH-1:0]    index
);

    // Scan high to low so the last hit written is the lowest clear index.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 2**ADDR_WIDTH - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                found = 1'b1;
                index = i[ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/cam_lookup_insert_ctrl.sv
// Request-side controller for the shift-register CAM: lookup / insert-if-absent / delete,
// owning the occupancy bitmap and sequencing the CAM's multi-cycle writes.
module cam_lookup_insert_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic [1:0]                                     req_op,
    input  logic [DATA_WIDTH-1:0]                          req_key,
    output logic                                           rsp_valid,
    input  logic                                           rsp_ready,
    output logic                                           rsp_hit,
    output logic [ADDR_WIDTH-1:0]                          rsp_addr,
    output logic                                           rsp_full,
    output logic [ADDR_WIDTH:0]                            occupancy,
    output logic [ADDR_WIDTH-1:0]                          cam_write_addr,
    output logic [DATA_WIDTH-1:0]                          cam_write_data,
    output logic                                           cam_write_delete,
    output logic                                           cam_write_enable,
    output logic [(DATA_WIDTH+SLICE_WIDTH-1)/SLICE_WIDTH-1:0] cam_select_mask,
    input  logic                                           cam_write_busy,
    output logic [DATA_WIDTH-1:0]                          cam_compare_data,
    input  logic                                           cam_match,
    input  logic [ADDR_WIDTH-1:0]                          cam_match_addr
);

    localparam int unsigned        ENTRIES = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] OCC_MAX = ENTRIES[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] OCC_ONE = 1;

    state_e                  state, state_next;
    op_e                     op_reg;
    logic [DATA_WIDTH-1:0]   key_reg;
    logic [ENTRIES-1:0]      bitmap;
    logic                    wait_armed;
    logic                    free_found;
    logic [ADDR_WIDTH-1:0]   free_idx;
    logic                    op_is_insert;
    logic                    op_is_delete;
    logic                    ins_room;

    free_slot_finder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_slot_finder (
        .bitmap (bitmap),
        .found  (free_found),
        .index  (free_idx)
    );

    // Reserved op code falls through to lookup behaviour.
    assign op_is_insert     = (op_reg == OP_INSERT);
    assign op_is_delete     = (op_reg == OP_DELETE);
    assign ins_room         = (occupancy < OCC_MAX) && free_found;

    assign req_ready        = (state == S_IDLE) && !cam_write_busy;
    assign rsp_valid        = (state == S_RESP);
    assign cam_write_enable = (state == S_ISSUE);
    assign cam_write_data   = key_reg;
    assign cam_compare_data = key_reg;
    assign cam_select_mask  = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (req_valid && req_ready) state_next = S_COMPARE;
            S_COMPARE: state_next = S_EVAL;
            S_EVAL: begin
                if (op_is_insert && !cam_match && ins_room) state_next = S_ISSUE;
                else if (op_is_delete && cam_match)         state_next = S_ISSUE;
                else                                        state_next = S_RESP;
            end
            S_ISSUE:   state_next = S_WAIT;
            // CAM busy only rises a cycle after the enable, so the first WAIT cycle is ignored.
            S_WAIT:    if (wait_armed && !cam_write_busy) state_next = S_RESP;
            S_RESP:    if (rsp_ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg           <= OP_LOOKUP;
            key_reg          <= '0;
            bitmap           <= '0;
            occupancy        <= '0;
            wait_armed       <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_addr         <= '0;
            rsp_full         <= 1'b0;
            cam_write_addr   <= '0;
            cam_write_delete <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_reg  <= op_e'(req_op);
                        key_reg <= req_key;
                    end
                end
                S_EVAL: begin
                    rsp_full <= 1'b0;
                    if (op_is_insert) begin
                        if (cam_match) begin
                            rsp_hit  <= 1'b1;
                            rsp_addr <= cam_match_addr;
                        end else if (ins_room) begin
                            rsp_hit          <= 1'b0;
                            rsp_addr         <= free_idx;
                            cam_write_addr   <= free_idx;
                            cam_write_delete <= 1'b0;
                        end else begin
                            rsp_hit  <= 1'b0;
                            rsp_addr <= '0;
                            rsp_full <= 1'b1;
                        end
                    end else begin
                        rsp_hit  <= cam_match;
                        rsp_addr <= cam_match ? cam_match_addr : '0;
                        if (op_is_delete && cam_match) begin
                            cam_write_addr   <= cam_match_addr;
                            cam_write_delete <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    bitmap[cam_write_addr] <= !cam_write_delete;
                    occupancy  <= cam_write_delete ? occupancy - OCC_ONE : occupancy + OCC_ONE;
                    wait_armed <= 1'b0;
                end
                S_WAIT: begin
                    wait_armed <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // A CAM hit on an entry this block believes is free means the two views have diverged.
    a_match_is_occupied: assert property (@(posedge clk) disable iff (rst)
        (state == S_EVAL && cam_match) |-> bitmap[cam_match_addr]);

endmodule
